mem_port_arbiter: RTL

Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (MEM), replacing the separate IMem/DataMem instances. It serialises accesses through a registered request/acknowledge bus, gives data accesses priority with a starvation guard for fetch, and drives per-stage stall signals that feed the PC/IF_ID hold (`nop`) and EX/MEM hold logic. A watchdog aborts hung accesses and flags an error.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 64;

  // Arbiter FSM states: one BUSY/RESP pair per requester.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_IF,
    ST_BUSY_DM,
    ST_RESP_IF,
    ST_RESP_DM
  } arb_state_e;

  // Bits needed for a counter that must be able to hold maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: pulses timeout in the TIMEOUT-th consecutive enabled cycle.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int            CW   = cntWidth(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count cycles spent busy; restart whenever the arbiter leaves a BUSY state.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout = enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins unless fetch has already been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_IF,
  output logic              stall_MEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  localparam int            SW         = cntWidth(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e        r_state;
  arb_state_e        w_stateNext;
  logic [SW-1:0]     r_starveCnt;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dmRdata;
  logic              r_ifValid;
  logic              r_dmValid;
  logic              r_busErr;

  logic w_dmPend;
  logic w_idle;
  logic w_busy;
  logic w_grantDm;
  logic w_grantIf;
  logic w_timeout;

  assign w_dmPend  = dm_read | dm_write;
  assign w_idle    = (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_DM);
  assign w_grantDm = w_idle && w_dmPend && (!if_req || (r_starveCnt < STARVE_MAX));
  assign w_grantIf = w_idle && !w_grantDm && if_req;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!w_busy),
    .enable (w_busy),
    .timeout(w_timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: grant in IDLE, finish on ack or watchdog, one RESP cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grantDm) begin
          w_stateNext = ST_BUSY_DM;
        end else if (w_grantIf) begin
          w_stateNext = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF: if (mem_ack || w_timeout) w_stateNext = ST_RESP_IF;
      ST_BUSY_DM: if (mem_ack || w_timeout) w_stateNext = ST_RESP_DM;
      ST_RESP_IF: w_stateNext = ST_IDLE;
      ST_RESP_DM: w_stateNext = ST_IDLE;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  // Consecutive data grants taken while fetch waits; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (w_idle) begin
      if (!if_req || w_grantIf) begin
        r_starveCnt <= '0;
      end else if (w_grantDm && (r_starveCnt != STARVE_MAX)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
    end
  end

  // Memory bus, read-data capture, completion pulses and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_ifRdata  <= '0;
      r_dmRdata  <= '0;
      r_ifValid  <= 1'b0;
      r_dmValid  <= 1'b0;
      r_busErr   <= 1'b0;
    end else begin
      r_ifValid <= 1'b0;
      r_dmValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grantDm) begin
            r_memReq   <= 1'b1;
            r_memWe    <= dm_write;
            r_memAddr  <= dm_addr;
            r_memWdata <= dm_wdata;
          end else if (w_grantIf) begin
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b0;
            r_memAddr  <= if_addr;
            r_memWdata <= '0;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ack) begin
            r_ifRdata <= mem_rdata;
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_ifValid <= 1'b1;
          end else if (w_timeout) begin
            r_ifRdata <= '0;
            r_busErr  <= 1'b1;
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_ifValid <= 1'b1;
          end
        end
        ST_BUSY_DM: begin
          if (mem_ack) begin
            if (!r_memWe) begin
              r_dmRdata <= mem_rdata;
            end
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_dmValid <= 1'b1;
          end else if (w_timeout) begin
            r_dmRdata <= '0;
            r_busErr  <= 1'b1;
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_dmValid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign if_rdata  = r_ifRdata;
  assign dm_rdata  = r_dmRdata;
  assign if_valid  = r_ifValid;
  assign dm_valid  = r_dmValid;
  assign bus_err   = r_busErr;
  assign stall_IF  = if_req & ~r_ifValid;
  assign stall_MEM = w_dmPend & ~r_dmValid;

endmodule
